// File: rtl/wb_regfile.sv
// Writeback commit into a 16-entry register file, two bypassed read ports, pending-write scoreboard.
// Writes land at the next edge (same-cycle bypass); out_stall holds decode issue, writeback never stalls.
module wb_regfile #(
    parameter int IALU_WORD_WIDTH = 16,
    parameter int REG_IDX_WIDTH   = 4,
    parameter int CNT_WIDTH       = 16
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       in_act_write_res_to_reg,
    input  logic [IALU_WORD_WIDTH-1:0] in_res,
    input  logic [REG_IDX_WIDTH-1:0]   in_res_reg_idx,
    input  logic [REG_IDX_WIDTH-1:0]   in_rs1_idx,
    input  logic [REG_IDX_WIDTH-1:0]   in_rs2_idx,
    input  logic                       in_rs1_used,
    input  logic                       in_rs2_used,
    input  logic                       in_issue_act,
    input  logic [REG_IDX_WIDTH-1:0]   in_issue_rd_idx,
    output logic [IALU_WORD_WIDTH-1:0] out_rs1_data,
    output logic [IALU_WORD_WIDTH-1:0] out_rs2_data,
    output logic                       out_stall,
    output logic [CNT_WIDTH-1:0]       out_wb_count
);
    localparam int NREG = 2 ** REG_IDX_WIDTH;

    logic [IALU_WORD_WIDTH-1:0] r_regs [NREG];
    logic [NREG-1:0]            r_pending;
    logic [CNT_WIDTH-1:0]       r_wb_count;

    logic            w_wb1;
    logic            w_wb2;
    logic            w_wb_rd;
    logic            w_raw1;
    logic            w_raw2;
    logic            w_waw;
    logic            w_stall;
    logic [NREG-1:0] w_pending_nxt;

    assign w_wb1   = in_act_write_res_to_reg && (in_res_reg_idx == in_rs1_idx);
    assign w_wb2   = in_act_write_res_to_reg && (in_res_reg_idx == in_rs2_idx);
    assign w_wb_rd = in_act_write_res_to_reg && (in_res_reg_idx == in_issue_rd_idx);

    // A writeback presented this cycle releases its own pending bit combinationally.
    assign w_raw1  = in_rs1_used && r_pending[in_rs1_idx] && !w_wb1;
    assign w_raw2  = in_rs2_used && r_pending[in_rs2_idx] && !w_wb2;
    assign w_waw   = in_issue_act && r_pending[in_issue_rd_idx] && !w_wb_rd;
    assign w_stall = w_raw1 | w_raw2 | w_waw;

    assign out_rs1_data = w_wb1 ? in_res : r_regs[in_rs1_idx];
    assign out_rs2_data = w_wb2 ? in_res : r_regs[in_rs2_idx];
    assign out_stall    = w_stall;
    assign out_wb_count = r_wb_count;

    // Clear first, then set: a newly issued write to the same index is younger and wins.
    always_comb begin
        w_pending_nxt = r_pending;
        if (in_act_write_res_to_reg) begin
            w_pending_nxt[in_res_reg_idx] = 1'b0;
        end
        if (in_issue_act && !w_stall) begin
            w_pending_nxt[in_issue_rd_idx] = 1'b1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                r_regs[i] <= '0;
            end
            r_pending  <= '0;
            r_wb_count <= '0;
        end else begin
            if (in_act_write_res_to_reg) begin
                r_regs[in_res_reg_idx] <= in_res;
                r_wb_count             <= r_wb_count + CNT_WIDTH'(1);
            end
            r_pending <= w_pending_nxt;
        end
    end
endmodule
